// File: rtl/mem_arbiter_pkg.sv
// Shared bus types for the core-side ports and the arbitrated memory port.
// No logic here. Optional round-robin arbitration is enabled with ARB_ROUND_ROBIN_EN.
package mem_arbiter_pkg;

    localparam int BUS_ADDR_W = 64;
    localparam int BUS_DATA_W = 64;
    localparam int BUS_STRB_W = BUS_DATA_W / 8;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic                  valid;
        logic [BUS_ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic                  valid;
        logic [BUS_ADDR_W-1:0] addr;
        msize_t                size;
        logic [BUS_STRB_W-1:0] strobe;
        logic [BUS_DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic                  addr_ok;
        logic                  data_ok;
        logic [BUS_DATA_W-1:0] data;
    } dbus_resp_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  is_write;
        logic [BUS_ADDR_W-1:0] addr;
        msize_t                size;
        logic [BUS_STRB_W-1:0] strobe;
        logic [BUS_DATA_W-1:0] data;
    } cbus_req_t;

    // Instructions are 32-bit; address bit 2 picks the half of the 64-bit word.
    function automatic logic [31:0] sel_word(input logic [63:0] word, input logic hi);
        return hi ? word[63:32] : word[31:0];
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Grant select between ibus and dbus; purely combinational, zero latency.
// No backpressure of its own. ARB_ROUND_ROBIN_EN: last_grant (0 = ibus) breaks ties, else dbus wins.
module mem_arbiter_arb_select (
    input  logic ivalid,
    input  logic dvalid,
    input  logic last_grant,
    output logic gnt_i,
    output logic gnt_d
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (ivalid && dvalid) begin
            // The side that did not win last time takes the tie.
            gnt_d = ~last_grant;
            gnt_i = last_grant;
        end else begin
            gnt_d = dvalid;
            gnt_i = ivalid;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        gnt_d = dvalid;
        gnt_i = ivalid & ~dvalid;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serializes ibus/dbus onto one memory port; grant -> creq_valid next cycle -> data_ok one cycle after cresp_ok.
// Requests are level-held until data_ok; the loser simply waits. ARB_ROUND_ROBIN_EN enables fair tie-breaking.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  ibus_req_t           ireq,
    output ibus_resp_t          iresp,
    input  dbus_req_t           dreq,
    output dbus_resp_t          dresp,
    output logic                creq_valid,
    output logic                creq_is_write,
    output logic [ADDR_W-1:0]   creq_addr,
    output logic [2:0]          creq_size,
    output logic [DATA_W/8-1:0] creq_strobe,
    output logic [DATA_W-1:0]   creq_data,
    input  logic                cresp_ok,
    input  logic [DATA_W-1:0]   cresp_data
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    msize_t              size_q, size_d;
    logic [STRB_W-1:0]   strobe_q, strobe_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                gnt_i;
    logic                gnt_d;
    logic                last_grant;
    cbus_req_t           creq;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (gnt_i || gnt_d)) begin
            last_grant_d = gnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = 1'b0;
`endif

    mem_arbiter_arb_select u_arb_select (
        .ivalid     (ireq.valid),
        .dvalid     (dreq.valid),
        .last_grant (last_grant),
        .gnt_i      (gnt_i),
        .gnt_d      (gnt_d)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        iresp    = '0;
        dresp    = '0;

        case (state_q)
            IDLE: begin
                // addr_ok is combinational from the request, so keep it quiet while reset is held.
                if (!reset && gnt_d) begin
                    addr_d        = dreq.addr;
                    size_d        = dreq.size;
                    strobe_d      = dreq.strobe;
                    wdata_d       = dreq.data;
                    dresp.addr_ok = 1'b1;
                    state_d       = BUSY_D;
                end else if (!reset && gnt_i) begin
                    addr_d        = ireq.addr;
                    size_d        = MSIZE4;
                    strobe_d      = '0;
                    wdata_d       = '0;
                    iresp.addr_ok = 1'b1;
                    state_d       = BUSY_I;
                end
            end
            BUSY_I: begin
                if (cresp_ok) begin
                    rdata_d = cresp_data;
                    state_d = RESP_I;
                end
            end
            BUSY_D: begin
                if (cresp_ok) begin
                    rdata_d = cresp_data;
                    state_d = RESP_D;
                end
            end
            RESP_I: begin
                iresp.data_ok = 1'b1;
                state_d       = IDLE;
            end
            RESP_D: begin
                dresp.data_ok = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        iresp.data = sel_word(rdata_q, addr_q[2]);
        dresp.data = rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= MSIZE1;
            strobe_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Memory-side fields come straight from the latch so they stay stable for the whole wait.
    always_comb begin
        creq          = '0;
        creq.valid    = (state_q == BUSY_I) || (state_q == BUSY_D);
        creq.is_write = |strobe_q;
        creq.addr     = addr_q;
        creq.size     = size_q;
        creq.strobe   = strobe_q;
        creq.data     = wdata_q;
    end

    assign creq_valid    = creq.valid;
    assign creq_is_write = creq.is_write;
    assign creq_addr     = creq.addr;
    assign creq_size     = creq.size;
    assign creq_strobe   = creq.strobe;
    assign creq_data     = creq.data;

endmodule
